dot_feeder: RTL and testbench
=============================

DOT_FEEDER -- requirements
Module: dot_feeder

Interface
REQ-001 Parameter width_p, default 32: operand width in bits.
REQ-002 Parameter depth_p, default 8: maximum vector length in operand pairs; SHALL be a power of two, at least 2.
REQ-003 Port clk_i, input, 1: single clock; all state updates on rising edge.
REQ-004 Port reset_i, input, 1: reset, asynchronous and active-low.
REQ-005 Port load_valid_i, input, 1: load pair present.
REQ-006 Port load_ready_o, output, 1: feeder can accept a load pair.
REQ-007 Port load_a_i / load_b_i, input, width_p each: operand pair.
REQ-008 Port load_last_i, input, 1: marks the final pair of a vector.
REQ-009 Port a_valid_o / b_valid_o, output, 1 each: operand offered to the downstream MAC.
REQ-010 Port a_ready_i / b_ready_i, input, 1 each: MAC can accept the respective operand.
REQ-011 Port a_o / b_o, output, width_p each: operands to the MAC.
REQ-012 Port flush_o, output, 1: one-cycle pulse telling the MAC the vector is complete.
REQ-013 Port busy_o, output, 1: high in any state other than IDLE.

Function
REQ-014 The block SHALL have a state machine with states IDLE, FILL, STREAM and FLUSH, plus a depth_p-entry pair buffer, a write pointer wp and a read pointer rp.
REQ-015 Load handshake: a pair is written to buffer[wp] and wp increments only on a cycle with load_valid_i & load_ready_o.
REQ-016 load_ready_o SHALL be 1 in IDLE and FILL, and 0 in STREAM and FLUSH.
REQ-017 Transitions from IDLE: accepted pair without last goes to FILL; accepted pair with last goes directly to STREAM.
REQ-018 Transitions from FILL: accepted pair with load_last_i, or the depth_p-th accepted pair (buffer full), goes to STREAM; the full case is treated as an implicit last.
REQ-019 STREAM: a_valid_o = b_valid_o = 1, a_o = buffer[rp].a, b_o = buffer[rp].b; valids and data SHALL hold stable until transfer.
REQ-020 A pair transfers only on a cycle with a_ready_i & b_ready_i both high; a single ready SHALL NOT advance rp.
REQ-021 On transfer of the pair at rp == wp-1, the next state is FLUSH; otherwise rp increments.
REQ-022 FLUSH lasts exactly one cycle: flush_o = 1, valids = 0, wp and rp cleared, next state IDLE.
REQ-023 In all states other than STREAM, a_valid_o and b_valid_o SHALL be 0. In all states other than FLUSH, flush_o SHALL be 0.
REQ-024 Latency: for a vector that arrives in consecutive cycles and is consumed with both readies held high, the first pair is offered the cycle after the last load, and flush_o follows the last transfer by exactly one cycle.
REQ-025 Pointers SHALL be clog2(depth_p) bits plus a count bit, so that a full buffer is distinguishable from an empty one; no wrap-around occurs inside a vector.
REQ-026 Operands pass through unmodified; the block performs no arithmetic on the data.

Reset
REQ-027 While reset_i is 0, and asynchronously on assertion, the following SHALL hold: state = IDLE, wp = rp = 0, a_valid_o = b_valid_o = flush_o = busy_o = 0, load_ready_o = 1.
REQ-028 Buffer contents are not reset.
REQ-029 Reset asserted mid-FILL or mid-STREAM SHALL discard the partial vector and SHALL NOT emit flush_o.

Verification
REQ-030 Single pair: load (322, 465) with last, both readies held at 1 -> one transfer of a_o = 322, b_o = 465, then flush_o for exactly one cycle, then busy_o = 0.
REQ-031 Two pairs: load (322, 465), then (1750, 33824) with last; readies held at 1 -> transfers occur in load order on consecutive cycles, followed by one flush_o pulse; a MAC model accumulates 59,341,730.
REQ-032 Backpressure: during STREAM, a_ready_i = 1 and b_ready_i = 0 for 3 cycles -> a_o/b_o held stable, rp unchanged, no flush_o; transfer occurs the first cycle both readies are 1.
REQ-033 Full buffer: load depth_p pairs with no last -> load_ready_o falls after the 8th acceptance; all 8 pairs stream in order; flush_o pulses once.
REQ-034 Loading is blocked during STREAM: load_valid_i held high -> no buffer write occurs until after FLUSH returns the block to IDLE.
REQ-035 Reset mid-STREAM after 1 of 3 transfers -> outputs immediately take their reset values, with no flush_o; a subsequent new vector streams correctly from entry 0.

Source files
------------

// File: rtl/dot_feeder.sv
// dot_feeder: buffers one vector of operand pairs, then streams it to a MAC and pulses flush
module dot_feeder #(
   parameter int width_p = 32,
   parameter int depth_p = 8
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               load_valid_i,
   output logic               load_ready_o,
   input  logic [width_p-1:0] load_a_i,
   input  logic [width_p-1:0] load_b_i,
   input  logic               load_last_i,
   output logic               a_valid_o,
   output logic               b_valid_o,
   input  logic               a_ready_i,
   input  logic               b_ready_i,
   output logic [width_p-1:0] a_o,
   output logic [width_p-1:0] b_o,
   output logic               flush_o,
   output logic               busy_o
);
   localparam int aw = $clog2(depth_p);
   localparam int pw = aw + 1;

   typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;

   state_t               state;
   logic [pw-1:0]        wp, rp;
   logic [width_p-1:0]   a_mem [depth_p];
   logic [width_p-1:0]   b_mem [depth_p];
   logic                 load_fire, xfer;

   assign load_ready_o = (state == IDLE) || (state == FILL);
   assign load_fire    = load_valid_i & load_ready_o;
   assign xfer         = (state == STREAM) & a_ready_i & b_ready_i;
   assign a_valid_o    = state == STREAM;
   assign b_valid_o    = state == STREAM;
   assign flush_o      = state == FLUSH;
   assign busy_o       = state != IDLE;
   assign a_o          = a_mem[rp[aw-1:0]];
   assign b_o          = b_mem[rp[aw-1:0]];

   // pair buffer: written on accepted loads, deliberately not reset
   always_ff @(posedge clk_i) begin
      if (load_fire) begin
         a_mem[wp[aw-1:0]] <= load_a_i;
         b_mem[wp[aw-1:0]] <= load_b_i;
      end
   end

   // control FSM: fill until last or full, stream until the last written pair drains, flush once
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state <= IDLE;
         wp    <= '0;
         rp    <= '0;
      end else begin
         case (state)
            IDLE: if (load_fire) begin
               wp    <= wp + pw'(1);
               state <= load_last_i ? STREAM : FILL;
            end
            FILL: if (load_fire) begin
               wp <= wp + pw'(1);
               if (load_last_i || wp == pw'(depth_p - 1)) state <= STREAM;
            end
            STREAM: if (xfer) begin
               if (rp == wp - pw'(1)) state <= FLUSH;
               else rp <= rp + pw'(1);
            end
            default: begin
               wp    <= '0;
               rp    <= '0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dot_feeder.sv
// tb_dot_feeder: directed vectors with a scoreboard queue checked by an independent monitor
module tb_dot_feeder;
   localparam int w = 32;
   localparam int d = 8;

   logic         clk_i = 0;
   logic         reset_i = 0;
   logic         load_valid_i = 0, load_last_i = 0;
   logic [w-1:0] load_a_i = 0, load_b_i = 0;
   logic         a_ready_i = 0, b_ready_i = 0;
   logic         load_ready_o, a_valid_o, b_valid_o, flush_o, busy_o;
   logic [w-1:0] a_o, b_o;

   int          vec = 0, errs = 0, flushes = 0;
   logic [63:0] acc = 0;
   logic        prev_flush = 0;
   logic [63:0] q[$];

   dot_feeder #(.width_p(w), .depth_p(d)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
      .load_a_i(load_a_i), .load_b_i(load_b_i), .load_last_i(load_last_i),
      .a_valid_o(a_valid_o), .b_valid_o(b_valid_o),
      .a_ready_i(a_ready_i), .b_ready_i(b_ready_i),
      .a_o(a_o), .b_o(b_o), .flush_o(flush_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // monitor: pops the scoreboard on every transfer, counts flush pulses
   always @(negedge clk_i) begin
      if (reset_i) begin
         if (a_valid_o !== b_valid_o) check("valid_pair", {63'd0, b_valid_o}, {63'd0, a_valid_o});
         if (a_valid_o && a_ready_i && b_ready_i) begin
            if (q.size() == 0) check("unexpected_xfer", {a_o, b_o}, 64'd0);
            else begin
               logic [63:0] e;
               e = q.pop_front();
               check("xfer_ab", {a_o, b_o}, e);
               acc += 64'(a_o) * 64'(b_o);
            end
         end
         if (flush_o) begin
            flushes++;
            if (prev_flush) check("flush_width", 64'd2, 64'd1);
         end
         prev_flush = flush_o;
      end else prev_flush = 0;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic load(input logic [w-1:0] a, input logic [w-1:0] b, input logic last);
      check("load_ready", {63'd0, load_ready_o}, 64'd1);
      load_valid_i = 1;
      load_a_i = a;
      load_b_i = b;
      load_last_i = last;
      q.push_back({a, b});
      tick();
      load_valid_i = 0;
      load_last_i = 0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50 && busy_o; i++) @(negedge clk_i);
      check("idle_timeout", {63'd0, busy_o}, 64'd0);
      tick();
   endtask

   initial begin
      int f0;
      #3;
      check("rst_ready", {63'd0, load_ready_o}, 64'd1);
      check("rst_busy", {63'd0, busy_o}, 64'd0);
      check("rst_valid", {62'd0, a_valid_o, b_valid_o}, 64'd0);
      check("rst_flush", {63'd0, flush_o}, 64'd0);
      tick();
      tick();
      reset_i = 1;
      a_ready_i = 1;
      b_ready_i = 1;
      tick();

      // single pair with latency checks
      acc = 0;
      f0 = flushes;
      load(322, 465, 1);
      check("single_offer", {63'd0, a_valid_o}, 64'd1);
      tick();
      check("single_flush", {63'd0, flush_o}, 64'd1);
      check("single_flush_novalid", {63'd0, a_valid_o}, 64'd0);
      tick();
      check("single_busy", {63'd0, busy_o}, 64'd0);
      check("single_acc", acc, 64'd149730);
      check("single_flushes", 64'(flushes - f0), 64'd1);

      // two pairs, MAC accumulation
      acc = 0;
      f0 = flushes;
      load(322, 465, 0);
      load(1750, 33824, 1);
      check("two_offer_a", {32'd0, a_o}, 64'd322);
      wait_idle();
      check("two_acc", acc, 64'd59341730);
      check("two_flushes", 64'(flushes - f0), 64'd1);

      // backpressure: single readies must not advance
      f0 = flushes;
      a_ready_i = 1;
      b_ready_i = 0;
      load(7, 9, 0);
      load(11, 13, 1);
      for (int i = 0; i < 3; i++) begin
         check("bp_valid", {63'd0, a_valid_o}, 64'd1);
         check("bp_hold", {a_o, b_o}, {32'd7, 32'd9});
         check("bp_noflush", {63'd0, flush_o}, 64'd0);
         tick();
      end
      a_ready_i = 0;
      b_ready_i = 1;
      tick();
      check("bp_hold_b", {a_o, b_o}, {32'd7, 32'd9});
      a_ready_i = 1;
      wait_idle();
      check("bp_flushes", 64'(flushes - f0), 64'd1);

      // full buffer: implicit last after depth pairs
      f0 = flushes;
      for (int i = 0; i < d; i++) load(32'(i * 3 + 1), 32'(i + 100), 0);
      check("full_ready_low", {63'd0, load_ready_o}, 64'd0);
      check("full_busy", {63'd0, busy_o}, 64'd1);
      wait_idle();
      check("full_flushes", 64'(flushes - f0), 64'd1);

      // loading blocked while streaming
      f0 = flushes;
      a_ready_i = 0;
      b_ready_i = 0;
      load(5, 6, 1);
      load_valid_i = 1;
      load_a_i = 99;
      load_b_i = 98;
      for (int i = 0; i < 3; i++) begin
         check("blk_ready", {63'd0, load_ready_o}, 64'd0);
         tick();
      end
      load_valid_i = 0;
      a_ready_i = 1;
      b_ready_i = 1;
      wait_idle();
      check("blk_flushes", 64'(flushes - f0), 64'd1);

      // reset mid-stream after one of three transfers
      f0 = flushes;
      a_ready_i = 1;
      b_ready_i = 0;
      load(21, 22, 0);
      load(23, 24, 0);
      load(25, 26, 1);
      b_ready_i = 1;
      tick();
      b_ready_i = 0;
      check("rs_advanced", {a_o, b_o}, {32'd23, 32'd24});
      #2;
      reset_i = 0;
      #1;
      check("rs_valid", {62'd0, a_valid_o, b_valid_o}, 64'd0);
      check("rs_busy", {63'd0, busy_o}, 64'd0);
      check("rs_ready", {63'd0, load_ready_o}, 64'd1);
      check("rs_flush", {63'd0, flush_o}, 64'd0);
      q.delete();
      tick();
      reset_i = 1;
      check("rs_noflush", 64'(flushes - f0), 64'd0);
      b_ready_i = 1;
      acc = 0;
      load(41, 42, 0);
      check("rs_new_first", {a_o, b_o}, {32'd41, 32'd42});
      load(43, 44, 1);
      wait_idle();
      check("rs_acc", acc, 64'(41 * 42 + 43 * 44));
      check("rs_flushes", 64'(flushes - f0), 64'd1);

      check("queue_empty", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
